// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state/owner types and default widths for the memory arbiter
package mem_arb_pkg;
  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM} arb_state_e;
  typedef enum logic {OWN_IF, OWN_DM} owner_e;
endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: 2-way selector, DM wins a tie unless DM owned the last grant
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic       if_req,
  input  logic       dm_req,
  input  owner_e     last_owner,
  output logic [1:0] gnt
);
  assign gnt = (dm_req & (~if_req | last_owner == OWN_IF)) ? 2'b10 : if_req ? 2'b01 : 2'b00;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: one-outstanding IF/DM arbiter onto a shared memory port; MEM_ARB_RR_EN selects round-robin ties
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int STRB_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  input  logic [STRB_W-1:0] dm_wstrb,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [STRB_W-1:0] mem_wstrb,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              core_stall,
  output logic              proto_err
);
  arb_state_e        state_q, state_d;
  logic              mem_req_q, mem_req_d, if_gnt_q, if_gnt_d, dm_gnt_q, dm_gnt_d;
  logic              we_q, we_d, proto_err_q, proto_err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0] wstrb_q, wstrb_d;
  logic [1:0]        gnt;
  logic              busy, arb_pt, issue, win_dm;
  owner_e            last_owner;

  mem_arb_pick u_pick (.if_req(if_req), .dm_req(dm_req), .last_owner(last_owner), .gnt(gnt));

  assign busy   = state_q != IDLE;
  assign arb_pt = ~busy | mem_rvalid;
  assign issue  = arb_pt & |gnt;
  assign win_dm = gnt[1];

`ifdef MEM_ARB_RR_EN
  owner_e last_owner_q, last_owner_d;
  // remember who took the latest grant so the other side wins the next tie
  always_comb last_owner_d = issue ? (win_dm ? OWN_DM : OWN_IF) : last_owner_q;
  // last-owner register
  always_ff @(posedge clk) last_owner_q <= rst ? OWN_IF : last_owner_d;
  assign last_owner = last_owner_q;
`else
  assign last_owner = OWN_IF;
`endif

  // next state: issue the winner at an arbitration point, hold fields while busy
  always_comb begin
    state_d     = issue ? (win_dm ? BUSY_DM : BUSY_IF) : arb_pt ? IDLE : state_q;
    mem_req_d   = issue;
    if_gnt_d    = issue & ~win_dm;
    dm_gnt_d    = issue & win_dm;
    we_d        = issue ? win_dm & dm_we : we_q;
    addr_d      = issue ? (win_dm ? dm_addr : if_addr) : addr_q;
    wdata_d     = issue ? (win_dm ? dm_wdata : '0) : wdata_q;
    wstrb_d     = issue ? ((win_dm & dm_we) ? dm_wstrb : '0) : wstrb_q;
    proto_err_d = proto_err_q | (~busy & mem_rvalid);
  end

  // state and latched transaction registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      if_gnt_q    <= 1'b0;
      dm_gnt_q    <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      if_gnt_q    <= if_gnt_d;
      dm_gnt_q    <= dm_gnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign mem_req    = mem_req_q;
  assign if_gnt     = if_gnt_q;
  assign dm_gnt     = dm_gnt_q;
  assign mem_we     = we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign mem_wstrb  = wstrb_q;
  assign proto_err  = proto_err_q;
  assign if_rvalid  = (state_q == BUSY_IF) & mem_rvalid;
  assign dm_rvalid  = (state_q == BUSY_DM) & mem_rvalid;
  assign if_rdata   = mem_rdata;
  assign dm_rdata   = mem_rdata;
  assign core_stall = (if_req | dm_req | busy) & ~(busy & mem_rvalid);
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter
module tb_mem_arbiter;
  logic        clk = 1'b0, rst;
  logic        if_req, if_gnt, if_rvalid;
  logic [31:0] if_addr, if_rdata;
  logic        dm_req, dm_we, dm_gnt, dm_rvalid;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic [3:0]  dm_wstrb, mem_wstrb;
  logic        mem_req, mem_we, mem_rvalid, core_stall, proto_err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  int          n_run = 0, n_fail = 0;
  logic [2:0]  exp_dm_order;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_wstrb(dm_wstrb),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .core_stall(core_stall), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
`ifdef MEM_ARB_RR_EN
    exp_dm_order = 3'b101;
`else
    exp_dm_order = 3'b111;
`endif
    rst = 1; if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0; dm_addr = 0;
    dm_wdata = 0; dm_wstrb = 0; mem_rvalid = 0; mem_rdata = 0;
    step(); step();
    chk("rst_mem_req", mem_req, 0);
    chk("rst_if_gnt", if_gnt, 0);
    chk("rst_dm_gnt", dm_gnt, 0);
    chk("rst_proto_err", proto_err, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_wstrb", mem_wstrb, 0);
    chk("rst_stall", core_stall, 0);
    rst = 0;
    step();
    // lone fetch, latency 1
    if_req = 1; if_addr = 32'h8000_0000; #1;
    chk("f_stall0", core_stall, 1);
    step();
    chk("f_if_gnt", if_gnt, 1);
    chk("f_mem_req", mem_req, 1);
    chk("f_mem_addr", mem_addr, 32'h8000_0000);
    chk("f_mem_wstrb", mem_wstrb, 0);
    chk("f_mem_we", mem_we, 0);
    chk("f_stall1", core_stall, 1);
    if_req = 0;
    step();
    chk("f_gnt_drop", if_gnt, 0);
    chk("f_req_drop", mem_req, 0);
    mem_rvalid = 1; mem_rdata = 32'h0000_0013; #1;
    chk("f_if_rvalid", if_rvalid, 1);
    chk("f_if_rdata", if_rdata, 32'h0000_0013);
    chk("f_dm_rvalid", dm_rvalid, 0);
    chk("f_stall2", core_stall, 0);
    step();
    mem_rvalid = 0; #1;
    chk("f_idle_stall", core_stall, 0);
    chk("f_idle_rvalid", if_rvalid, 0);
    // conflict: DM store first, then fetch with no gap
    if_req = 1; if_addr = 32'h8000_0004;
    dm_req = 1; dm_we = 1; dm_addr = 32'h100; dm_wdata = 32'hDEAD_BEEF; dm_wstrb = 4'hF;
    step();
    chk("c_dm_gnt", dm_gnt, 1);
    chk("c_if_gnt", if_gnt, 0);
    chk("c_mem_req", mem_req, 1);
    chk("c_mem_we", mem_we, 1);
    chk("c_mem_addr", mem_addr, 32'h100);
    chk("c_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    chk("c_mem_wstrb", mem_wstrb, 4'hF);
    dm_req = 0; dm_we = 0;
    step();
    chk("c_no_req", mem_req, 0);
    mem_rvalid = 1; mem_rdata = 0; #1;
    chk("c_dm_rvalid", dm_rvalid, 1);
    chk("c_if_rvalid", if_rvalid, 0);
    chk("c_stall", core_stall, 0);
    step();
    mem_rvalid = 0;
    chk("c2_if_gnt", if_gnt, 1);
    chk("c2_mem_req", mem_req, 1);
    chk("c2_mem_addr", mem_addr, 32'h8000_0004);
    chk("c2_mem_we", mem_we, 0);
    chk("c2_mem_wstrb", mem_wstrb, 0);
    if_req = 0;
    step();
    mem_rvalid = 1; mem_rdata = 32'h1234_5678; #1;
    chk("c2_if_rvalid", if_rvalid, 1);
    chk("c2_if_rdata", if_rdata, 32'h1234_5678);
    step();
    mem_rvalid = 0;
    // three back-to-back conflicts, both requesters always high
    if_req = 1; if_addr = 32'h8000_0008; dm_req = 1; dm_we = 0; dm_addr = 32'h104;
    for (int k = 0; k < 3; k++) begin
      step();
      mem_rvalid = 0;
      chk($sformatf("rr%0d_dm_gnt", k), dm_gnt, exp_dm_order[k]);
      chk($sformatf("rr%0d_if_gnt", k), if_gnt, !exp_dm_order[k]);
      chk($sformatf("rr%0d_mem_req", k), mem_req, 1);
      step();
      mem_rvalid = 1;
    end
    if_req = 0; dm_req = 0;
    step();
    mem_rvalid = 0;
    chk("rr_idle_req", mem_req, 0);
    // long latency store
    dm_req = 1; dm_we = 1; dm_addr = 32'h200; dm_wdata = 32'hCAFE_F00D; dm_wstrb = 4'h3;
    step();
    chk("l_dm_gnt", dm_gnt, 1);
    chk("l_mem_req", mem_req, 1);
    dm_req = 0; dm_we = 0; dm_addr = 32'h999; dm_wdata = 0; dm_wstrb = 0;
    for (int i = 1; i < 5; i++) begin
      step();
      chk($sformatf("l%0d_mem_req", i), mem_req, 0);
      chk($sformatf("l%0d_dm_gnt", i), dm_gnt, 0);
      chk($sformatf("l%0d_addr", i), mem_addr, 32'h200);
      chk($sformatf("l%0d_wdata", i), mem_wdata, 32'hCAFE_F00D);
      chk($sformatf("l%0d_wstrb", i), mem_wstrb, 4'h3);
      chk($sformatf("l%0d_stall", i), core_stall, 1);
    end
    step();
    mem_rvalid = 1; #1;
    chk("l_dm_rvalid", dm_rvalid, 1);
    chk("l_mem_req5", mem_req, 0);
    chk("l_addr5", mem_addr, 32'h200);
    step();
    mem_rvalid = 0;
    chk("l_no_gnt", dm_gnt, 0);
    // reset mid-transaction, then a late response
    dm_req = 1; dm_addr = 32'h300;
    step();
    chk("r_dm_gnt", dm_gnt, 1);
    dm_req = 0;
    step();
    rst = 1;
    step();
    rst = 0;
    chk("r_mem_addr", mem_addr, 0);
    chk("r_proto_clr", proto_err, 0);
    chk("r_stall", core_stall, 0);
    mem_rvalid = 1; #1;
    chk("r_dm_rvalid", dm_rvalid, 0);
    chk("r_if_rvalid", if_rvalid, 0);
    step();
    mem_rvalid = 0;
    chk("r_proto_err", proto_err, 1);
    // stray response while idle, from a clean reset
    rst = 1;
    step();
    rst = 0;
    chk("s_proto_clr", proto_err, 0);
    mem_rvalid = 1; #1;
    chk("s_if_rvalid", if_rvalid, 0);
    chk("s_dm_rvalid", dm_rvalid, 0);
    step();
    mem_rvalid = 0;
    chk("s_proto_set", proto_err, 1);
    step(); step(); step();
    chk("s_proto_held", proto_err, 1);
    chk("s_mem_req", mem_req, 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares one unified memory port between the core's instruction-fetch requester (IF) and data-memory requester (DM), replacing the separate instruction and data memories. It holds one transaction outstanding at a time, latches the winner's address and data, and routes the response back to the owner. It drives a stall to the core's PC/writeback logic while either requester is waiting.

Parameters:
ADDR_W, 32, address width of all ports
DATA_W, 32, data width; must be a multiple of 8
STRB_W, DATA_W/8, byte-strobe width

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  synchronous active-high reset
if_req  in  1  fetch request; held until if_gnt
if_addr  in  ADDR_W  fetch address
if_gnt  out  1  one-cycle pulse: fetch accepted
if_rvalid  out  1  fetch data valid
if_rdata  out  DATA_W  fetch data
dm_req  in  1  data request; held until dm_gnt
dm_we  in  1  1 = store, 0 = load
dm_addr  in  ADDR_W  data address
dm_wdata  in  DATA_W  store data
dm_wstrb  in  STRB_W  store byte enables
dm_gnt  out  1  one-cycle pulse: data accepted
dm_rvalid  out  1  load data valid or store acknowledged
dm_rdata  out  DATA_W  load data
mem_req  out  1  one-cycle issue pulse to memory
mem_we  out  1  write enable
mem_addr  out  ADDR_W  latched address
mem_wdata  out  DATA_W  latched store data
mem_wstrb  out  STRB_W  latched strobes; all zero on reads
mem_rvalid  in  1  response/ack, at least 1 cycle after mem_req
mem_rdata  in  DATA_W  read data, valid with mem_rvalid
core_stall  out  1  high while any req is high and not yet answered
proto_err  out  1  sticky: mem_rvalid seen while IDLE

Behaviour:
- States: IDLE, BUSY_IF, BUSY_DM. Owner is encoded in the state.
- Reset: state=IDLE. mem_req, if_gnt, dm_gnt, proto_err = 0. Latched mem_addr, mem_wdata, mem_wstrb and mem_we = 0. Rvalids are 0 because the state is IDLE.
- Arbitration point: in IDLE, or in BUSY_x in the cycle mem_rvalid=1.
  - Fixed priority: DM wins over IF.
  - Winner's fields are registered into mem_*. Next cycle: mem_req=1 and the winner's gnt=1 (both single-cycle), and state becomes BUSY_winner.
- Back-to-back issue: a completing transaction with a pending req issues the next one with zero idle cycles. mem_req is never high in two consecutive cycles, because mem_rvalid arrives at least 1 cycle after mem_req.
- Response routing is combinational from mem_rvalid, gated by state.
  - BUSY_IF: if_rvalid = mem_rvalid, if_rdata = mem_rdata.
  - BUSY_DM: same, onto dm_rvalid and dm_rdata.
  - The non-owner's rvalid is 0. Its rdata is don't-care; drive mem_rdata.
- Completion without pending req: BUSY_x with mem_rvalid and no req returns to IDLE.
- Stores complete on mem_rvalid. dm_rvalid is asserted for the ack; dm_rdata is don't-care.
- Requester obligations:
  - Deassert req, or present a new request, the cycle after gnt.
  - A req still high after its own gnt is a new request.
  - Stalled requesters hold their fields stable.
- Stray response: mem_rvalid while IDLE is ignored; proto_err is set and stays set until rst.
- Reset mid-transaction: returns to IDLE and drops the outstanding transaction. A late mem_rvalid after reset sets proto_err; it is not routed.
- core_stall = (if_req & ~if_gnt-pending-completion) | owner-not-yet-rvalid. Equivalent form: core_stall = (if_req | dm_req | state!=IDLE) & ~(the owning requester's rvalid this cycle).

Optional Feature:
MEM_ARB_RR_EN
- Defined: round-robin priority.
  - A 1-bit last_owner register, reset to IF, means DM wins the next simultaneous conflict.
  - last_owner updates on every grant.
  - The loser of a conflict wins the next conflict.
- Undefined: fixed DM-over-IF priority and no last_owner register.
- Single-requester behaviour is identical either way.

Decomposition:
- Shared package mem_arb_pkg holds:
  - the arb_state_e typedef (IDLE, BUSY_IF, BUSY_DM);
  - the owner_e typedef (OWN_IF, OWN_DM);
  - the default ADDR_W and DATA_W constants.
- One natural sub-module: mem_arb_pick, a combinational 2-way priority/round-robin selector that takes if_req, dm_req and last_owner and produces the grant vector.

Test Plan:
- Lone fetch: if_req=1, addr 0x80000000, memory latency 1 → if_gnt pulse at cycle+1 with mem_req=1, mem_addr=0x80000000, mem_wstrb=0; if_rvalid=1 with mem_rdata=0x00000013 at cycle+2; core_stall high until then.
- Conflict, fixed priority: if_req and dm_req both high in IDLE, dm_we=1, dm_addr=0x100, dm_wdata=0xDEADBEEF, dm_wstrb=0xF → DM issued first; on its mem_rvalid the fetch issues the next cycle with no idle gap.
- Round-robin with MEM_ARB_RR_EN: three consecutive conflicts → grant order DM, IF, DM. Without the macro: DM, DM, DM.
- Long latency: 5-cycle mem_rvalid delay → exactly one mem_req pulse; mem_addr, mem_wdata and mem_wstrb stable all 5 cycles; no second gnt.
- Reset mid-op: rst asserted in BUSY_DM, then mem_rvalid after reset → state IDLE, dm_rvalid=0, proto_err=1.
- Stray response: mem_rvalid in IDLE with no request → no rvalid to either side, proto_err=1 and held.
